// File: rtl/vga_fb_scanner.sv
// VGA framebuffer scanner: generates raster timing, framebuffer read
// addresses (with optional pixel replication) and sync/blank outputs
// delayed to line up with the memory read data. Buffer swaps are latched
// on the last pixel of a frame so the display never tears.
// Optional feature: define VGA_FB_SCANNER_TESTPAT_EN to add an internal
// vertical-bar test pattern selected by the testpat input.
module vga_fb_scanner #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int ADDR_W     = 19,
  parameter int IDX_W      = 8,
  parameter int RD_LAT     = 1,
  parameter int SCALE_LOG2 = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base_a,
  input  logic [ADDR_W-1:0] fb_base_b,
  input  logic              buf_sel_req,
  input  logic              testpat,
  input  logic [IDX_W-1:0]  vga_index,
  output logic [ADDR_W-1:0] vga_addr,
  output logic              vga_rd_en,
  output logic [IDX_W-1:0]  index_out,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_n,
  output logic              frame_start,
  output logic              buf_sel_cur
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  // Low bits of v_cnt that select the replicated line within a scaled row.
  localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE >> SCALE_LOG2);

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [VW-1:0]     v_next;
  logic [ADDR_W-1:0] row_acc;
  logic [ADDR_W-1:0] base;
  logic [HW-1:0]     h_pix;
  logic              h_wrap;
  logic              v_wrap;
  logic              row_step_en;
  logic              active;
  logic              hs_raw;
  logic              vs_raw;
  logic              out_on;
  logic [RD_LAT-1:0] hs_pipe;
  logic [RD_LAT-1:0] vs_pipe;
  logic [RD_LAT-1:0] act_pipe;

  // Raster decode from the current counter position.
  always_comb begin
    h_wrap      = (h_cnt == H_LAST);
    v_wrap      = (v_cnt == V_LAST);
    v_next      = v_cnt + VW'(1);
    row_step_en = ((v_next & V_MASK) == '0);
    active      = enable && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_raw      = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_raw      = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    out_on      = resetn & enable;
    base        = buf_sel_cur ? fb_base_b : fb_base_a;
    h_pix       = h_cnt >> SCALE_LOG2;
  end

  // Pixel/line counters and the row-offset accumulator; idle holds at (0,0).
  always_ff @(posedge clock) begin
    if (!resetn || !enable) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      row_acc <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      if (v_wrap) begin
        v_cnt   <= '0;
        row_acc <= '0;
      end else begin
        v_cnt <= v_next;
        if (row_step_en) row_acc <= row_acc + ROW_STEP;
      end
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Displayed buffer only changes on the very last pixel of a frame.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      buf_sel_cur <= 1'b0;
    end else if (enable && h_wrap && v_wrap) begin
      buf_sel_cur <= buf_sel_req;
    end
  end

  // Delay syncs and blank by the memory latency; flush while idle.
  always_ff @(posedge clock) begin
    if (!resetn || !enable) begin
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      act_pipe <= '0;
    end else begin
      hs_pipe  <= RD_LAT'({hs_pipe, hs_raw});
      vs_pipe  <= RD_LAT'({vs_pipe, vs_raw});
      act_pipe <= RD_LAT'({act_pipe, active});
    end
  end

  assign vga_addr    = base + row_acc + ADDR_W'(h_pix);
  assign oHS         = out_on ? hs_pipe[RD_LAT-1] : 1'b1;
  assign oVS         = out_on ? vs_pipe[RD_LAT-1] : 1'b1;
  assign oBLANK_n    = out_on & act_pipe[RD_LAT-1];
  assign frame_start = out_on && (h_cnt == '0) && (v_cnt == '0);

`ifdef VGA_FB_SCANNER_TESTPAT_EN
  localparam int PW = IDX_W + 3;

  logic [RD_LAT*PW-1:0] hpos_pipe;
  logic [PW-1:0]        hpos_d;
  logic [2:0]           unused_hpos_lsb;

  // Horizontal position delayed alongside blank, used for the bar pattern.
  always_ff @(posedge clock) begin
    if (!resetn || !enable) begin
      hpos_pipe <= '0;
    end else begin
      hpos_pipe <= (RD_LAT*PW)'({hpos_pipe, PW'(h_cnt)});
    end
  end

  assign hpos_d          = hpos_pipe[RD_LAT*PW-1 -: PW];
  assign unused_hpos_lsb = hpos_d[2:0];
  assign vga_rd_en       = out_on & active & ~testpat;
  assign index_out       = !oBLANK_n ? '0 : (testpat ? hpos_d[IDX_W+2:3] : vga_index);
`else
  logic unused_testpat;

  assign unused_testpat = testpat;
  assign vga_rd_en      = out_on & active;
  assign index_out      = oBLANK_n ? vga_index : '0;
`endif

endmodule

// File: tb/tb_vga_fb_scanner.sv
// Self-checking bench for vga_fb_scanner on a tiny 14x7 raster.
module tb_vga_fb_scanner;

  logic       clock = 1'b0;
  logic       resetn;
  logic       enable;
  logic [7:0] fb_base_a;
  logic [7:0] fb_base_b;
  logic       buf_sel_req;
  logic       testpat;
  logic [7:0] vga_index;
  logic [7:0] vga_addr;
  logic       vga_rd_en;
  logic [7:0] index_out;
  logic       oHS, oVS, oBLANK_n, frame_start, buf_sel_cur;
  logic [7:0] vga_addr_s;
  logic       vga_rd_en_s;
  logic [7:0] index_out_s;
  logic       oHS_s, oVS_s, oBLANK_n_s, frame_start_s, buf_sel_cur_s;

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Framebuffer memory with one cycle of read latency.
  always @(posedge clock) vga_index <= mem[vga_addr];

  vga_fb_scanner #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ADDR_W(8), .IDX_W(8), .RD_LAT(1), .SCALE_LOG2(0)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .fb_base_a(fb_base_a), .fb_base_b(fb_base_b),
    .buf_sel_req(buf_sel_req), .testpat(testpat), .vga_index(vga_index),
    .vga_addr(vga_addr), .vga_rd_en(vga_rd_en), .index_out(index_out),
    .oHS(oHS), .oVS(oVS), .oBLANK_n(oBLANK_n),
    .frame_start(frame_start), .buf_sel_cur(buf_sel_cur)
  );

  vga_fb_scanner #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ADDR_W(8), .IDX_W(8), .RD_LAT(1), .SCALE_LOG2(1)
  ) dut_s (
    .clock(clock), .resetn(resetn), .enable(enable),
    .fb_base_a(fb_base_a), .fb_base_b(fb_base_b),
    .buf_sel_req(buf_sel_req), .testpat(testpat), .vga_index(vga_index),
    .vga_addr(vga_addr_s), .vga_rd_en(vga_rd_en_s), .index_out(index_out_s),
    .oHS(oHS_s), .oVS(oVS_s), .oBLANK_n(oBLANK_n_s),
    .frame_start(frame_start_s), .buf_sel_cur(buf_sel_cur_s)
  );

  // Reference raster: k counts cycles since (0,0) of the first frame.
  function automatic int m_h(int k); return (k % 98) % 14; endfunction
  function automatic int m_v(int k); return (k % 98) / 14; endfunction
  function automatic bit m_act(int k); return (m_h(k) < 8) && (m_v(k) < 4); endfunction
  function automatic bit m_hs(int k); return !(m_h(k) >= 10 && m_h(k) < 12); endfunction
  function automatic bit m_vs(int k); return m_v(k) != 5; endfunction
  function automatic logic [7:0] m_addr(logic [7:0] b, int k, int s);
    int a;
    a = int'(b) + (m_v(k) >> s) * (8 >> s) + (m_h(k) >> s);
    return 8'(a);
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reset, then release with enable=1; the next sample point is pixel (0,0).
  task automatic restart;
    resetn = 1'b0; enable = 1'b0; testpat = 1'b0; buf_sel_req = 1'b0;
    repeat (2) tick();
    resetn = 1'b1; enable = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; enable = 1'b1; testpat = 1'b0; buf_sel_req = 1'b1;
    fb_base_a = 8'($urandom); fb_base_b = 8'($urandom);
    repeat (3) tick();
    #1;
    checks += 7;
    if (oHS !== 1'b1) begin errors++; $display("FAIL reset_hs got %b exp 1", oHS); end
    if (oVS !== 1'b1) begin errors++; $display("FAIL reset_vs got %b exp 1", oVS); end
    if (oBLANK_n !== 1'b0) begin errors++; $display("FAIL reset_blank got %b exp 0", oBLANK_n); end
    if (vga_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", vga_rd_en); end
    if (index_out !== 8'h00) begin errors++; $display("FAIL reset_index got %h exp 00", index_out); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
    if (buf_sel_cur !== 1'b0) begin errors++; $display("FAIL reset_buf_sel got %b exp 0", buf_sel_cur); end
  endtask

  task automatic test_timing;
    int last_fs;
    bit e_hs, e_vs, e_bl;
    last_fs = -1;
    restart();
    for (int k = 0; k < 2 * 98 + 6; k++) begin
      #1;
      e_hs = (k == 0) ? 1'b1 : m_hs(k - 1);
      e_vs = (k == 0) ? 1'b1 : m_vs(k - 1);
      e_bl = (k == 0) ? 1'b0 : m_act(k - 1);
      checks += 5;
      if (oHS !== e_hs) begin errors++; $display("FAIL timing_hs k=%0d got %b exp %b", k, oHS, e_hs); end
      if (oVS !== e_vs) begin errors++; $display("FAIL timing_vs k=%0d got %b exp %b", k, oVS, e_vs); end
      if (oBLANK_n !== e_bl) begin errors++; $display("FAIL timing_blank k=%0d got %b exp %b", k, oBLANK_n, e_bl); end
      if (vga_rd_en !== m_act(k)) begin errors++; $display("FAIL timing_rd_en k=%0d got %b exp %b", k, vga_rd_en, m_act(k)); end
      if (frame_start !== (k % 98 == 0)) begin errors++; $display("FAIL timing_frame_start k=%0d got %b exp %b", k, frame_start, (k % 98 == 0)); end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          checks++;
          if (k - last_fs != 98) begin errors++; $display("FAIL timing_period got %0d exp 98", k - last_fs); end
        end
        last_fs = k;
      end
      tick();
    end
  endtask

  task automatic test_addressing(input logic [7:0] b, input bit ident);
    bit p_act;
    logic [7:0] p_addr, e_addr, e_idx;
    for (int i = 0; i < 256; i++) mem[i] = ident ? 8'(i) : 8'($urandom);
    fb_base_a = b; fb_base_b = ~b;
    p_act = 1'b0; p_addr = 8'h00;
    restart();
    for (int k = 0; k < 98 + 20; k++) begin
      if (!ident && k == 60) fb_base_a = 8'($urandom);
      #1;
      e_addr = m_addr(fb_base_a, k, 0);
      e_idx  = p_act ? mem[p_addr] : 8'h00;
      checks += 2;
      if (vga_addr !== e_addr) begin errors++; $display("FAIL addr k=%0d got %h exp %h", k, vga_addr, e_addr); end
      if (index_out !== e_idx) begin errors++; $display("FAIL index k=%0d got %h exp %h", k, index_out, e_idx); end
      p_act = m_act(k); p_addr = e_addr;
      tick();
    end
  endtask

  task automatic test_scaling;
    logic [7:0] e_addr;
    fb_base_a = 8'($urandom);
    restart();
    for (int k = 0; k < 98; k++) begin
      #1;
      e_addr = m_addr(fb_base_a, k, 1);
      checks++;
      if (vga_addr_s !== e_addr) begin errors++; $display("FAIL scale_addr k=%0d got %h exp %h", k, vga_addr_s, e_addr); end
      tick();
    end
  endtask

  task automatic test_buffer_swap;
    bit m_buf;
    int pos, frame, line;
    logic [7:0] e_addr;
    fb_base_a = 8'($urandom); fb_base_b = 8'hF8;
    m_buf = 1'b0;
    restart();
    for (int k = 0; k < 3 * 98 + 3; k++) begin
      pos = k % 98; frame = k / 98; line = pos / 14;
      case (frame)
        0: buf_sel_req = (line == 2 || line == 3 || line >= 5);
        1: buf_sel_req = !(line >= 1 && line <= 3);
        2: buf_sel_req = (line == 6) ? 1'b0 : 1'($urandom);
        default: buf_sel_req = 1'($urandom);
      endcase
      #1;
      e_addr = m_addr(m_buf ? fb_base_b : fb_base_a, k, 0);
      checks += 2;
      if (buf_sel_cur !== m_buf) begin errors++; $display("FAIL swap_buf_sel k=%0d got %b exp %b", k, buf_sel_cur, m_buf); end
      if (vga_addr !== e_addr) begin errors++; $display("FAIL swap_addr k=%0d got %h exp %h", k, vga_addr, e_addr); end
      if (frame == 1 && pos == 8) begin
        checks++;
        if (vga_addr !== 8'h00) begin errors++; $display("FAIL swap_wrap got %h exp 00", vga_addr); end
      end
      if (pos == 97) m_buf = buf_sel_req;
      tick();
    end
  endtask

  task automatic test_enable_reset;
    int n;
    logic [7:0] ba, bb;
    ba = 8'($urandom); bb = 8'($urandom);
    fb_base_a = ba; fb_base_b = bb;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
    restart();
    n = 14 * $urandom_range(0, 3) + $urandom_range(2, 6);
    for (int k = 0; k < n; k++) tick();
    enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks += 6;
      if (oHS !== 1'b1) begin errors++; $display("FAIL en_off_hs c=%0d got %b exp 1", c, oHS); end
      if (oVS !== 1'b1) begin errors++; $display("FAIL en_off_vs c=%0d got %b exp 1", c, oVS); end
      if (oBLANK_n !== 1'b0) begin errors++; $display("FAIL en_off_blank c=%0d got %b exp 0", c, oBLANK_n); end
      if (vga_rd_en !== 1'b0) begin errors++; $display("FAIL en_off_rd_en c=%0d got %b exp 0", c, vga_rd_en); end
      if (index_out !== 8'h00) begin errors++; $display("FAIL en_off_index c=%0d got %h exp 00", c, index_out); end
      if (frame_start !== 1'b0) begin errors++; $display("FAIL en_off_frame_start c=%0d got %b exp 0", c, frame_start); end
      tick();
    end
    enable = 1'b1;
    #1;
    checks += 3;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL en_on_frame_start got %b exp 1", frame_start); end
    if (vga_addr !== ba) begin errors++; $display("FAIL en_on_addr got %h exp %h", vga_addr, ba); end
    if (oBLANK_n !== 1'b0) begin errors++; $display("FAIL en_on_blank got %b exp 0", oBLANK_n); end
    tick();
    #1;
    checks += 2;
    if (oBLANK_n !== 1'b1) begin errors++; $display("FAIL en_on_blank2 got %b exp 1", oBLANK_n); end
    if (vga_addr !== 8'(ba + 8'd1)) begin errors++; $display("FAIL en_on_addr2 got %h exp %h", vga_addr, 8'(ba + 8'd1)); end

    // Swap to buffer B, then reset at pixel (5,2) of the following frame.
    restart();
    buf_sel_req = 1'b1;
    for (int k = 0; k < 98 + 33; k++) tick();
    #1;
    checks += 2;
    if (buf_sel_cur !== 1'b1) begin errors++; $display("FAIL rst_pre_buf got %b exp 1", buf_sel_cur); end
    if (vga_addr !== 8'(bb + 8'd21)) begin errors++; $display("FAIL rst_pre_addr got %h exp %h", vga_addr, 8'(bb + 8'd21)); end
    resetn = 1'b0;
    tick();
    #1;
    checks += 4;
    if (buf_sel_cur !== 1'b0) begin errors++; $display("FAIL rst_buf got %b exp 0", buf_sel_cur); end
    if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start got %b exp 0", frame_start); end
    if (oBLANK_n !== 1'b0) begin errors++; $display("FAIL rst_blank got %b exp 0", oBLANK_n); end
    if (vga_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b exp 0", vga_rd_en); end
    resetn = 1'b1;
    #1;
    checks += 3;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL rst_rel_frame_start got %b exp 1", frame_start); end
    if (vga_addr !== ba) begin errors++; $display("FAIL rst_rel_addr got %h exp %h", vga_addr, ba); end
    if (buf_sel_cur !== 1'b0) begin errors++; $display("FAIL rst_rel_buf got %b exp 0", buf_sel_cur); end
    tick();
  endtask

  task automatic test_testpat;
    bit p_act;
    logic [7:0] p_addr, e_idx;
    bit e_rd;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
    fb_base_a = 8'($urandom);
    p_act = 1'b0; p_addr = 8'h00;
    restart();
    testpat = 1'b1;
    for (int k = 0; k < 98 + 14; k++) begin
      #1;
`ifdef VGA_FB_SCANNER_TESTPAT_EN
      e_rd  = 1'b0;
      e_idx = 8'h00;
`else
      e_rd  = m_act(k);
      e_idx = p_act ? mem[p_addr] : 8'h00;
`endif
      checks += 2;
      if (vga_rd_en !== e_rd) begin errors++; $display("FAIL testpat_rd_en k=%0d got %b exp %b", k, vga_rd_en, e_rd); end
      if (index_out !== e_idx) begin errors++; $display("FAIL testpat_index k=%0d got %h exp %h", k, index_out, e_idx); end
      p_act = m_act(k); p_addr = m_addr(fb_base_a, k, 0);
      tick();
    end
    testpat = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; enable = 1'b0; testpat = 1'b0; buf_sel_req = 1'b0;
    fb_base_a = 8'h00; fb_base_b = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_timing();
    test_addressing(8'h20, 1'b1);
    test_addressing(8'($urandom), 1'b0);
    test_scaling();
    test_buffer_swap();
    test_enable_reset();
    test_testpat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanner.md
VGA_FB_SCANNER -- requirements
Module: vga_fb_scanner

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-low; the ports are named clock and resetn.
REQ-002 SHALL provide these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- ADDR_W, 19, framebuffer address width.
- IDX_W, 8, palette index width.
- RD_LAT, 1, framebuffer read latency in cycles (legal 1..3).
- SCALE_LOG2, 0, pixel replication exponent (legal 0..2).
REQ-003 SHALL provide these ports (name, direction, width, meaning):
- clock, in, 1, pixel clock.
- resetn, in, 1, synchronous active-low reset.
- enable, in, 1, scan enable.
- fb_base_a, in, ADDR_W, base address of buffer A.
- fb_base_b, in, ADDR_W, base address of buffer B.
- buf_sel_req, in, 1, requested display buffer (0 = A, 1 = B).
- testpat, in, 1, test-pattern request.
- vga_index, in, IDX_W, memory read data.
- vga_addr, out, ADDR_W, framebuffer read address.
- vga_rd_en, out, 1, read strobe.
- index_out, out, IDX_W, pixel index aligned with the syncs.
- oHS, out, 1, horizontal sync, active-low.
- oVS, out, 1, vertical sync, active-low.
- oBLANK_n, out, 1, high during active video.
- frame_start, out, 1, one-cycle pulse at pixel (0,0).
- buf_sel_cur, out, 1, buffer currently displayed.

Function
REQ-004 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise for the vertical parameters.
REQ-005 SHALL, while enable is high, advance h_cnt by 1 per cycle, wrapping from H_TOTAL-1 to 0; v_cnt SHALL advance only on that h wrap and SHALL wrap from V_TOTAL-1 to 0.
REQ-006 SHALL treat a cycle as active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-007 SHALL make raw HS low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and raw VS low for v_cnt in the equivalent vertical window.
REQ-008 SHALL drive vga_rd_en = active, combinationally from the counters, so it asserts in the same cycle as the corresponding vga_addr.
REQ-009 SHALL drive vga_addr = base + (v_cnt>>SCALE_LOG2)*(H_ACTIVE>>SCALE_LOG2) + (h_cnt>>SCALE_LOG2), computed modulo 2^ADDR_W.
REQ-010 SHALL compute the vga_addr row offset incrementally using an accumulator register, with no multiplier.
REQ-011 SHALL select base = fb_base_b when buf_sel_cur=1, otherwise fb_base_a.
REQ-012 SHALL delay raw HS, raw VS and active through an RD_LAT-stage shift register to produce oHS, oVS and oBLANK_n, so they align with vga_index.
REQ-013 SHALL drive index_out = vga_index when the delayed active is 1, otherwise 0.
REQ-014 SHALL latch buf_sel_req into buf_sel_cur only on the cycle with h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, so buffer swaps are tear-free.
REQ-015 SHALL ignore toggles of buf_sel_req mid-frame; only the value sampled at REQ-014 takes effect.
REQ-016 SHALL assert frame_start for exactly one cycle when h_cnt=0 and v_cnt=0 while enable=1, undelayed.
REQ-017 SHALL, when enable=0, hold both counters at 0 and force oHS=1, oVS=1, oBLANK_n=0, vga_rd_en=0 and index_out=0.
REQ-018 SHALL, when enable rises, make the first counted cycle pixel (0,0) and pulse frame_start.
REQ-019 SHALL flush the delay pipeline to the inactive values whenever enable=0.
REQ-020 SHALL make fb_base_a and fb_base_b changes take effect on the next cycle's address, without buffering.

Reset
REQ-021 SHALL, on a clock edge with resetn=0, set h_cnt=0, v_cnt=0, buf_sel_cur=0, the row accumulator to 0, and all pipeline stages to the inactive values.
REQ-022 SHALL drive these outputs during reset: oHS=1, oVS=1, oBLANK_n=0, vga_rd_en=0, index_out=0, frame_start=0.
REQ-023 SHALL, when reset is applied mid-frame, abort the frame with no partial-line output.
REQ-024 SHALL, after release with enable=1, start at pixel (0,0).

Configuration
REQ-025 SHALL, with VGA_FB_SCANNER_TESTPAT_EN defined and testpat=1, make index_out = h_cnt_delayed[IDX_W+2:3] (vertical bars, 8 pixels wide) during the delayed-active window, and hold vga_rd_en=0.
REQ-026 SHALL, without VGA_FB_SCANNER_TESTPAT_EN, ignore testpat and omit all test-pattern logic.

Verification
Unless noted, the bench uses H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), ADDR_W=8, IDX_W=8, RD_LAT=1, SCALE_LOG2=0.
REQ-027 SHALL cover timing: reset then enable=1 -> oHS low for h_cnt 10..11 delayed 1 cycle, oVS low on line 5, frame_start period 98 cycles.
REQ-028 SHALL cover addressing: fb_base_a=0x20 -> vga_addr sequence 0x20..0x27 on line 0 and 0x38..0x3F on line 3; a memory model returning addr as data -> index_out equals the address of one cycle earlier.
REQ-029 SHALL cover scaling: SCALE_LOG2=1 -> vga_addr on lines 0 and 1 = base+0,0,1,1,2,2,3,3; lines 2 and 3 = base+4..7 pairwise.
REQ-030 SHALL cover the buffer swap: buf_sel_req toggled at line 2 -> buf_sel_cur changes only after (13,6); the next frame reads from fb_base_b; fb_base_b=0xF8 wraps to 0x00 at pixel 8.
REQ-031 SHALL cover enable and reset: enable dropped mid-line -> the next cycle shows oHS=1, oVS=1, oBLANK_n=0; resetn=0 at (5,2) -> the next cycle counters=0 and buf_sel_cur=0.
REQ-032 SHALL cover the test pattern (macro defined): testpat=1 -> vga_rd_en=0, and index_out=0 for pixels 0..7 of every active line.
